// File: rtl/led_zone_scheduler.sv
// rtl/led_zone_scheduler.sv - LED zone frame scheduler: FIFO reads into a 2-entry skid buffer feeding a valid/ready stream; optional macro LED_UNDERFLOW_FILL_EN
module led_zone_scheduler #(
    parameter int ZONE_NUM   = 384,
    parameter int DATA_W     = 24,
    parameter int UF_TIMEOUT = 1024
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              frame_start,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_skip,
    output logic              underflow
);

    localparam int CW = $clog2(ZONE_NUM + 1);
    localparam int UW = $clog2(UF_TIMEOUT + 1);
    localparam logic [CW-1:0] LP_ZONE_CNT  = CW'(ZONE_NUM);
    localparam logic [CW-1:0] LP_ZONE_LAST = CW'(ZONE_NUM - 1);
    localparam logic [UW-1:0] LP_UF_LAST   = UW'(UF_TIMEOUT - 1);
`ifdef LED_UNDERFLOW_FILL_EN
    localparam bit LP_FILL = 1'b1;
`else
    localparam bit LP_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_ABORT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_rd_cnt;
    logic [CW-1:0]     r_out_cnt;
    logic [UW-1:0]     r_uf_cnt;
    logic              r_underflow;
    logic              r_inflight;
    logic              r_inflight_zero;
    logic              r_frame_done;
    logic              r_frame_skip;
    logic [DATA_W-1:0] r_skid [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_skid_cnt;

    logic w_accept;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_space;
    logic w_fill;
    logic w_issue;
    logic w_uf_hit;
    logic w_last_hs;
    logic w_flush;

    // A frame is accepted only in IDLE and not in the cycle frame_done is shown
    assign w_accept  = (r_state == S_IDLE) && frame_start && !r_frame_done;
    assign w_valid   = (r_skid_cnt != 2'd0) && (r_state != S_ABORT) && !rd_rst;
    assign w_pop     = w_valid && m_ready;
    // Count the slot freed by this cycle's pop so one beat per cycle is sustained
    assign w_space   = (({1'b0, r_skid_cnt} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
    assign w_fill    = LP_FILL && r_underflow;
    assign w_issue   = (r_state == S_BURST) && !rd_rst && (r_rd_cnt < LP_ZONE_CNT)
                       && w_space && (w_fill || !fifo_rd_empty);
    assign w_uf_hit  = (r_state == S_BURST) && fifo_rd_empty && !r_underflow
                       && (r_uf_cnt == LP_UF_LAST);
    assign w_last_hs = w_pop && (r_out_cnt == LP_ZONE_LAST);
    assign w_push    = r_inflight && (r_state != S_ABORT);
    assign w_flush   = (r_state == S_ABORT);

    assign fifo_rd_en = w_issue && !w_fill;
    assign m_valid    = w_valid;
    assign m_data     = w_valid ? r_skid[r_rd_ptr] : '0;
    assign m_last     = w_valid && (r_out_cnt == LP_ZONE_LAST);
    assign frame_busy = (r_state != S_IDLE) && !rd_rst;
    assign frame_done = r_frame_done;
    assign frame_skip = r_frame_skip;
    assign underflow  = r_underflow;

    // State register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; without fill, underflow aborts the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BURST;
            S_BURST: begin
                if (w_uf_hit && !LP_FILL) begin
                    w_state_nxt = S_ABORT;
                end else if (w_issue && (r_rd_cnt == LP_ZONE_LAST)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Zone counters, underflow watchdog, in-flight tracking and status pulses
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rd_cnt        <= '0;
            r_out_cnt       <= '0;
            r_uf_cnt        <= '0;
            r_underflow     <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_zero <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_skip    <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_zero <= w_fill;
            r_frame_done    <= w_last_hs;
            r_frame_skip    <= frame_start && !w_accept;
            if (w_accept) begin
                r_rd_cnt    <= '0;
                r_out_cnt   <= '0;
                r_uf_cnt    <= '0;
                r_underflow <= 1'b0;
            end else begin
                if (w_issue) r_rd_cnt <= r_rd_cnt + CW'(1);
                if (w_pop)   r_out_cnt <= r_out_cnt + CW'(1);
                if ((r_state == S_BURST) && !r_underflow) begin
                    if (!fifo_rd_empty) begin
                        r_uf_cnt <= '0;
                    end else begin
                        r_uf_cnt <= r_uf_cnt + UW'(1);
                        if (w_uf_hit) r_underflow <= 1'b1;
                    end
                end
            end
        end
    end

    // Two-entry skid buffer; fill-mode words are captured as zero
    always_ff @(posedge rd_clk) begin
        if (rd_rst || w_flush) begin
            r_skid[0]  <= '0;
            r_skid[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_skid_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_skid[r_wr_ptr] <= r_inflight_zero ? '0 : fifo_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_skid_cnt <= (r_skid_cnt + {1'b0, w_push}) - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_led_zone_scheduler.sv
// tb/tb_led_zone_scheduler.sv - directed self-checking bench for led_zone_scheduler
module tb_led_zone_scheduler;

    logic        clk = 1'b0;
    logic        rd_rst;
    logic        frame_start;
    logic        fifo_rd_en;
    logic [23:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_skip;
    logic        underflow;

    logic [23:0] mem [0:4095];
    int          rd_idx = 0;
    int          wr_idx = 0;
    int          n_asserts = 0;
    int          n_fail = 0;

    led_zone_scheduler #(.ZONE_NUM(384), .DATA_W(24), .UF_TIMEOUT(16)) dut (
        .rd_clk        (clk),
        .rd_rst        (rd_rst),
        .frame_start   (frame_start),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done),
        .frame_skip    (frame_skip),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    assign fifo_rd_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx] = 24'h100000 + 24'(wr_idx);
            wr_idx      = wr_idx + 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fifo_rd_en"}, fifo_rd_en, 0);
        check({tag, " m_valid"},    m_valid,    0);
        check({tag, " m_last"},     m_last,     0);
        check({tag, " m_data"},     m_data,     0);
        check({tag, " frame_busy"}, frame_busy, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_skip"}, frame_skip, 0);
        check({tag, " underflow"},  underflow,  0);
    endtask

    task automatic run_frame(input string tag, input int n_data, input int n_beats, input bit rnd,
                             input int skip_at, input bit exp_done, input bit start_at_done,
                             input bit chk_lat);
        int base, beat, cyc, first_rd, first_val, last_cyc, done_cyc, skip_cyc, sad_cyc;
        int empty_cyc, uf_cyc;
        bit stall_pend, fin;
        logic [23:0] stall_data, exp_w;
        base = rd_idx; beat = 0; cyc = 0; first_rd = -1; first_val = -1; last_cyc = -1;
        done_cyc = -1; skip_cyc = -1; sad_cyc = -1; empty_cyc = -1; uf_cyc = -1;
        stall_pend = 1'b0; fin = 1'b0; stall_data = '0;
        @(negedge clk);
        frame_start = 1'b1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            frame_start = 1'b0;
            if (cyc == 1) begin
                check({tag, " busy_at_start"}, frame_busy, 1);
                check({tag, " underflow_cleared"}, underflow, 0);
            end
            if (stall_pend) begin
                check({tag, " stall_valid"}, m_valid, 1);
                check({tag, " stall_data"}, m_data, stall_data);
            end
            if (skip_cyc >= 0 && cyc == skip_cyc + 1) check({tag, " skip_pulse"}, frame_skip, 1);
            if (sad_cyc >= 0 && cyc == sad_cyc + 1) begin
                check({tag, " skip_at_done"}, frame_skip, 1);
                check({tag, " idle_after_skip"}, frame_busy, 0);
            end
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_valid && first_val < 0) first_val = cyc;
            if (fifo_rd_empty && frame_busy && empty_cyc < 0) empty_cyc = cyc;
            if (underflow && uf_cyc < 0) uf_cyc = cyc;
            if (frame_done && done_cyc < 0) begin
                done_cyc = cyc;
                if (start_at_done) begin
                    frame_start = 1'b1;
                    sad_cyc     = cyc;
                end
            end
            if (skip_at >= 0 && beat == skip_at && skip_cyc < 0) begin
                frame_start = 1'b1;
                skip_cyc    = cyc;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall_pend = m_valid && !m_ready;
            stall_data = m_data;
            if (m_valid && m_ready) begin
                exp_w = (beat < n_data) ? mem[base + beat] : 24'h0;
                check($sformatf("%s beat%0d data", tag, beat), m_data, exp_w);
                check($sformatf("%s beat%0d last", tag, beat), m_last,
                      32'(exp_done && (beat == n_beats - 1)));
                beat++;
                last_cyc = cyc;
            end
            if (!frame_busy && cyc > 1 && !(sad_cyc >= 0 && cyc <= sad_cyc)) fin = 1'b1;
        end
        check({tag, " frame_ended"}, frame_busy, 0);
        check({tag, " beat_count"}, beat, n_beats);
        check({tag, " done_cycle"}, done_cyc, exp_done ? last_cyc + 1 : -1);
        check({tag, " underflow_end"}, underflow, 32'(n_data < 384));
        if (n_data < 384) check({tag, " underflow_delay"}, uf_cyc - empty_cyc, 16);
        if (chk_lat) begin
            check({tag, " first_valid_latency"}, first_val - first_rd, 2);
            check({tag, " back_to_back"}, last_cyc - first_val, n_beats - 1);
        end
    endtask

    initial begin
        int beat, cnt;
        rd_rst      = 1'b1;
        frame_start = 1'b0;
        m_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rd_rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        load(384);
        run_frame("full", 384, 384, 1'b0, -1, 1'b1, 1'b1, 1'b1);

        load(384);
        run_frame("random_ready", 384, 384, 1'b1, -1, 1'b1, 1'b0, 1'b0);

        load(384);
        run_frame("skip", 384, 384, 1'b0, 100, 1'b1, 1'b0, 1'b0);

        load(200);
`ifdef LED_UNDERFLOW_FILL_EN
        run_frame("uf_fill", 200, 384, 1'b0, -1, 1'b1, 1'b0, 1'b0);
`else
        run_frame("uf_abort", 200, 200, 1'b0, -1, 1'b0, 1'b0, 1'b0);
`endif

        load(384);
        @(negedge clk);
        frame_start = 1'b1;
        m_ready     = 1'b1;
        beat = 0;
        cnt  = 0;
        while (beat < 50 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            frame_start = 1'b0;
            if (cnt == 1) check("new_frame underflow_cleared", underflow, 0);
            if (m_valid) beat++;
        end
        check("rst_mid beats_reached", beat, 50);
        @(negedge clk);
        m_ready = 1'b0;
        rd_rst  = 1'b1;
        #1;
        check("rst_mid during fifo_rd_en", fifo_rd_en, 0);
        check("rst_mid during m_valid", m_valid, 0);
        check("rst_mid during frame_busy", frame_busy, 0);
        @(negedge clk);
        check_all_zero("rst_mid after");
        rd_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid no_done", frame_done, 0);
            check("rst_mid no_last", m_last, 0);
            check("rst_mid no_valid", m_valid, 0);
            check("rst_mid idle", frame_busy, 0);
        end
        load(384);
        run_frame("after_reset", 384, 384, 1'b0, -1, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
